// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths and FSM state type for the SRAM controller
package sram_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous 32-bit SRAM controller with programmable wait states
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [31:0]            address,
  input  logic [SRAM_BE_W-1:0]   byteenable_i,
  input  logic [SRAM_DATA_W-1:0] data_wr,
  output logic [SRAM_DATA_W-1:0] data_rd,
  output logic                   stall_o,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [SRAM_BE_W-1:0]   sram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sram_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [SRAM_DATA_W-1:0]     dq_o_q, dq_o_d;
  logic [SRAM_BE_W-1:0]       be_q, be_d;
  logic [SRAM_DATA_W-1:0]     data_rd_q, data_rd_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;
  logic [SRAM_BE_W-1:0]       be_n_q, be_n_d;
  logic                       dq_oe_q, dq_oe_d;

  // Only the word-address bits reach the SRAM; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[1:0], address[31:ADDR_WIDTH+2]};

  // Sequencing: accept in IDLE, count out the strobe phase, then hold/done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dq_o_d    = dq_o_q;
    be_d      = be_q;
    data_rd_d = data_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          state_d = ST_WRITE;
          cnt_d   = WR_CNT;
          addr_d  = address[ADDR_WIDTH+1:2];
          dq_o_d  = data_wr;
          be_d    = byteenable_i;
        end else if (read_i) begin
          state_d = ST_READ;
          cnt_d   = RD_CNT;
          addr_d  = address[ADDR_WIDTH+1:2];
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          data_rd_d = sram_dq_i;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pad is driven from a flop.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    dq_oe_d = 1'b0;
    case (state_d)
      ST_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      ST_WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~be_d;
      end
      ST_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~be_d;
      end
      default: ;
    endcase
  end

  // State and pad registers; reset parks every strobe inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      dq_o_q    <= '0;
      be_q      <= '0;
      data_rd_q <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= '1;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dq_o_q    <= dq_o_d;
      be_q      <= be_d;
      data_rd_q <= data_rd_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign stall_o    = (read_i | write_i) & (state_q != ST_DONE) & ~rst;
  assign data_rd    = data_rd_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl against a behavioural SRAM
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int AW        = 20;
  localparam int RDW       = 1;
  localparam int WRW       = 2;
  localparam int MEM_WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_i, write_i;
  logic [31:0]   address;
  logic [3:0]    byteenable_i;
  logic [31:0]   data_wr;
  logic [31:0]   data_rd;
  logic          stall_o;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  logic [31:0] last_read = 32'h0;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_WIDTH(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address(address),
    .byteenable_i(byteenable_i), .data_wr(data_wr), .data_rd(data_rd), .stall_o(stall_o),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Asynchronous SRAM: drives data while selected and output-enabled.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'h0;

  // SRAM write: enabled byte lanes follow the data bus while CE and WE are low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
  end

  // Bus contention watch: pad driver and SRAM output driver both on.
  always @(negedge clk)
    if (!sram_oe_n && sram_dq_oe) overlap_cnt <= overlap_cnt + 1;

  function automatic void ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a[11:2]] = w;
  endfunction

  // Master side: hold the request until stall_o drops, observing pins every cycle.
  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] d, input logic perturb,
                        output int stall_cyc, output int oe_cyc, output int we_cyc,
                        output int hold_cyc, output logic [AW-1:0] hold_addr,
                        output logic [3:0] be_n_we, output logic [31:0] rdata,
                        output logic done);
    stall_cyc = 0; oe_cyc = 0; we_cyc = 0; hold_cyc = 0;
    hold_addr = '0; be_n_we = 4'hF; rdata = 32'h0; done = 1'b0;
    read_i = rd; write_i = wr; address = addr; byteenable_i = be; data_wr = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cyc++;
      if (!sram_we_n) begin we_cyc++; be_n_we = sram_be_n; end
      if (sram_we_n && !sram_ce_n && sram_dq_oe) begin hold_cyc++; hold_addr = sram_addr; end
      if (stall_o) stall_cyc++;
      else begin done = 1'b1; rdata = data_rd; end
      if (perturb && c == 1) begin address = ~addr; data_wr = ~d; byteenable_i = ~be; end
    end
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address = '0; byteenable_i = '0; data_wr = '0;
    repeat (3) @(posedge clk);
    #1 read_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 8'b1111_1110) begin
      failures++; $display("FAIL reset_strobes got=%b exp=11111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe});
    end
    checks++;
    if (sram_addr !== '0 || sram_dq_o !== 32'h0) begin
      failures++; $display("FAIL reset_addr_data got addr=%h dq_o=%h exp 0/0", sram_addr, sram_dq_o);
    end
    checks++;
    if (data_rd !== 32'h0) begin failures++; $display("FAIL reset_data_rd got=%h exp=0", data_rd); end
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    read_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    mem[10'h040] = 32'hDEADBEEF; ref_mem[10'h040] = 32'hDEADBEEF;
    bus_op(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (!dn) begin failures++; $display("FAIL read_timeout done=%b exp=1", dn); end
    checks++;
    if (o != RDW + 1) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=%0d", o, RDW + 1); end
    checks++;
    if (s != RDW + 2) begin failures++; $display("FAIL read_stall_cycles got=%0d exp=%0d", s, RDW + 2); end
    checks++;
    if (rdat !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", rdat); end
    checks++;
    if (w != 0) begin failures++; $display("FAIL read_we_cycles got=%0d exp=0", w); end
    last_read = 32'hDEADBEEF;
  endtask

  task automatic test_write;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    ref_write(32'h200, 4'hF, 32'h12345678);
    bus_op(1'b0, 1'b1, 32'h200, 4'hF, 32'h12345678, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (w != WRW + 1) begin failures++; $display("FAIL write_we_cycles got=%0d exp=%0d", w, WRW + 1); end
    checks++;
    if (h != 1 || ha !== AW'(32'h80)) begin
      failures++; $display("FAIL write_hold got cycles=%0d addr=%h exp 1/80", h, ha);
    end
    checks++;
    if (s != WRW + 3) begin failures++; $display("FAIL write_stall_cycles got=%0d exp=%0d", s, WRW + 3); end
    checks++;
    if (mem[10'h080] !== 32'h12345678) begin failures++; $display("FAIL write_mem got=%h exp=12345678", mem[10'h080]); end
    checks++;
    if (data_rd !== last_read) begin failures++; $display("FAIL write_keeps_data_rd got=%h exp=%h", data_rd, last_read); end
  endtask

  task automatic test_byte_lane;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    mem[10'h081] = 32'h11223344; ref_mem[10'h081] = 32'h11223344;
    ref_write(32'h204, 4'b0100, 32'hAABBCCDD);
    bus_op(1'b0, 1'b1, 32'h204, 4'b0100, 32'hAABBCCDD, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (bn !== 4'b1011) begin failures++; $display("FAIL byte_lane_be_n got=%b exp=1011", bn); end
    checks++;
    if (mem[10'h081] !== 32'h11BB3344) begin failures++; $display("FAIL byte_lane_mem got=%h exp=11bb3344", mem[10'h081]); end
  endtask

  task automatic test_both_high;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    logic [31:0] d;
    d = $urandom;
    ref_write(32'h300, 4'hF, d);
    bus_op(1'b1, 1'b1, 32'h300, 4'hF, d, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (o != 0 || w != WRW + 1) begin
      failures++; $display("FAIL both_high got oe_cycles=%0d we_cycles=%0d exp 0/%0d", o, w, WRW + 1);
    end
    checks++;
    if (mem[10'h0C0] !== ref_mem[10'h0C0]) begin failures++; $display("FAIL both_high_mem got=%h exp=%h", mem[10'h0C0], ref_mem[10'h0C0]); end
  endtask

  task automatic test_reset_mid_write;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    logic [31:0] d;
    d = $urandom;
    read_i = 1'b0; write_i = 1'b1; address = 32'h400; byteenable_i = 4'hF; data_wr = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_mid_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b110) begin
      failures++; $display("FAIL reset_mid_strobes got we_n,ce_n,dq_oe=%b exp=110", {sram_we_n, sram_ce_n, sram_dq_oe});
    end
    @(posedge clk); #1;
    rst = 1'b0; write_i = 1'b0;
    ref_write(32'h400, 4'hF, d);
    @(posedge clk); #1;
    bus_op(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (s != RDW + 2 || rdat !== ref_mem[10'h100]) begin
      failures++; $display("FAIL reset_mid_recover got stall=%0d data=%h exp %0d/%h", s, rdat, RDW + 2, ref_mem[10'h100]);
    end
    last_read = rdat;
  endtask

  task automatic test_back_to_back;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    logic [31:0] a, d; logic [3:0] be; int t0;
    a = {20'h0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
    d = $urandom; be = 4'($urandom_range(1, 15));
    t0 = cyc;
    bus_op(1'b1, 1'b0, a, 4'hF, 32'h0, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (rdat !== ref_mem[a[11:2]]) begin failures++; $display("FAIL rmw_read got=%h exp=%h", rdat, ref_mem[a[11:2]]); end
    last_read = rdat;
    ref_write(a, be, (rdat & 32'h0) | d);
    bus_op(1'b0, 1'b1, a, be, d, 1'b0, s, o, w, h, ha, bn, rdat, dn);
    checks++;
    if (cyc - t0 != (RDW + 3) + (WRW + 4)) begin
      failures++; $display("FAIL rmw_cycles got=%0d exp=%0d", cyc - t0, (RDW + 3) + (WRW + 4));
    end
    checks++;
    if (mem[a[11:2]] !== ref_mem[a[11:2]]) begin failures++; $display("FAIL rmw_write got=%h exp=%h", mem[a[11:2]], ref_mem[a[11:2]]); end
  endtask

  task automatic test_random;
    int s, o, w, h; logic [AW-1:0] ha; logic [3:0] bn; logic [31:0] rdat; logic dn;
    logic [31:0] a, d; logic [3:0] be; int kind; logic pert; logic is_wr;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      is_wr = (kind != 0);
      a = {20'h0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'($urandom_range(0, 3))};
      d = $urandom; be = 4'($urandom_range(0, 15)); pert = 1'($urandom_range(0, 1));
      if (is_wr) ref_write(a, be, d);
      bus_op(kind != 1, is_wr, a, be, d, pert, s, o, w, h, ha, bn, rdat, dn);
      checks++;
      if (!dn || s != (is_wr ? WRW + 3 : RDW + 2) || o != (is_wr ? 0 : RDW + 1) || w != (is_wr ? WRW + 1 : 0)) begin
        failures++;
        $display("FAIL random_timing op=%0d kind=%0d got done=%b stall=%0d oe=%0d we=%0d", i, kind, dn, s, o, w);
      end
      checks++;
      if (is_wr) begin
        if (mem[a[11:2]] !== ref_mem[a[11:2]] || data_rd !== last_read) begin
          failures++;
          $display("FAIL random_write op=%0d got mem=%h data_rd=%h exp %h/%h", i, mem[a[11:2]], data_rd, ref_mem[a[11:2]], last_read);
        end
      end else begin
        if (rdat !== ref_mem[a[11:2]]) begin
          failures++; $display("FAIL random_read op=%0d got=%h exp=%h", i, rdat, ref_mem[a[11:2]]);
        end
        last_read = ref_mem[a[11:2]];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_read();
    test_write();
    test_byte_lane();
    test_both_high();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    checks++;
    if (overlap_cnt != 0) begin failures++; $display("FAIL dq_oe_oe_n_overlap got=%0d exp=0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
